// File: rtl/number_hit_scorer.sv
// ---------------------------------------------------------------------------
// number_hit_scorer
//
// Producer side of the multi-number display. Every pixel cycle it looks for
// overlaps between the player and each visible number. A number that was
// touched at any point during a frame is latched as "pending". At the next
// frame start the pending set is reported on singleHit for one cycle. A short
// scan then walks the numbers one per cycle. For each hit number the scan
// adds its digit value to a saturating BCD score and replaces the digit with
// a fresh pseudo-random value 1..9.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   startOfFrame   in   one-cycle pulse at frame start
//   numbersDR      in   [NUMBERS]     per-number drawing request, current pixel
//   playerDR       in   player drawing request, current pixel
//   showNum        in   [NUMBERS]     number currently visible
//   singleHit      out  [NUMBERS]     one-cycle hit pulse per number
//   numbersToShow  out  [NUMBERS*4]   digit per number (1..9), number j at [4j+3:4j]
//   score          out  [SCORE_DIGITS*4] BCD score, digit 0 least significant
//   busy           out  scan in progress
// ---------------------------------------------------------------------------
module number_hit_scorer #(
    parameter int         NUMBERS      = 3,
    parameter int         SCORE_DIGITS = 4,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic [NUMBERS-1:0]        numbersDR,
    input  logic                      playerDR,
    input  logic [NUMBERS-1:0]        showNum,
    output logic [NUMBERS-1:0]        singleHit,
    output logic [NUMBERS*4-1:0]      numbersToShow,
    output logic [SCORE_DIGITS*4-1:0] score,
    output logic                      busy
);

    localparam int IDX_W = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBERS - 1);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Power-on digit for number j: (j+1) mod 10, with 0 replaced by 1.
    function automatic logic [3:0] reset_digit(input int j);
        int v;
        v = (j + 1) % 10;
        if (v == 0) begin
            v = 1;
        end
        return 4'(v);
    endfunction

    // Fold the low LFSR nibble into 1..9. 10..15 map to 4..9 and 0 maps to 1.
    function automatic logic [3:0] lfsr_digit(input logic [7:0] l);
        logic [3:0] v;
        v = l[3:0];
        if (v == 4'd0) begin
            return 4'd1;
        end else if (v > 4'd9) begin
            return v - 4'd6;
        end else begin
            return v;
        end
    endfunction

    // Decimal add of a single digit into the score. The carry ripples through
    // every BCD digit in one cycle. Bit [SCORE_DIGITS*4] is the carry out of
    // the top digit.
    function automatic logic [SCORE_DIGITS*4:0] bcd_add(
        input logic [SCORE_DIGITS*4-1:0] s,
        input logic [3:0]                addend
    );
        logic [SCORE_DIGITS*4-1:0] r;
        logic [4:0]                carry;
        logic [4:0]                sum;
        r     = '0;
        carry = {1'b0, addend};
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            sum = {1'b0, s[i*4 +: 4]} + carry;
            if (sum > 5'd9) begin
                r[i*4 +: 4] = 4'(sum - 5'd10);
                carry       = 5'd1;
            end else begin
                r[i*4 +: 4] = sum[3:0];
                carry       = 5'd0;
            end
        end
        return {carry[0], r};
    endfunction

    // Overflow out of the top digit pins the score at all nines. Every addend
    // is at least 1, so a saturated score overflows again on each later hit
    // and stays pinned.
    function automatic logic [SCORE_DIGITS*4-1:0] sat_score(
        input logic [SCORE_DIGITS*4:0] sum_with_carry
    );
        if (sum_with_carry[SCORE_DIGITS*4]) begin
            return {SCORE_DIGITS{4'h9}};
        end else begin
            return sum_with_carry[SCORE_DIGITS*4-1:0];
        end
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]                state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [7:0]                lfsr_q;
    logic [NUMBERS-1:0]        pending_q;
    logic [NUMBERS-1:0]        hit_mask_q;
    logic [NUMBERS-1:0]        single_hit_q;
    logic                      busy_q;
    logic [SCORE_DIGITS*4-1:0] score_q;
    logic [3:0]                digits_q [NUMBERS];

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic [NUMBERS-1:0]        collision;
    logic                      consume;
    logic                      lfsr_fb;
    logic [3:0]                new_digit;
    logic [3:0]                sel_digit;
    logic                      sel_hit;
    logic [SCORE_DIGITS*4-1:0] score_next;

    // Invisible numbers are masked here, so they can never become pending.
    assign collision = {NUMBERS{playerDR}} & numbersDR & showNum;

    // Frames with nothing pending are ignored. Frame starts during a scan are
    // also ignored, and their pending hits wait for the next frame start.
    assign consume   = (state_q == S_IDLE) && startOfFrame && (|pending_q);

    // Taps x^8 + x^6 + x^5 + x^4 + 1 map to state bits 7, 5, 4 and 3.
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign new_digit = lfsr_digit(lfsr_q);

    // Explicit mux over the scan index. A non-power-of-two NUMBERS leaves
    // index codes with no matching entry, and those select nothing.
    always_comb begin
        sel_digit = '0;
        sel_hit   = 1'b0;
        for (int i = 0; i < NUMBERS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_digit = digits_q[i];
                sel_hit   = hit_mask_q[i];
            end
        end
    end

    assign score_next = sat_score(bcd_add(score_q, sel_digit));

    // -----------------------------------------------------------------------
    // LFSR: runs freely whenever reset is low
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
        end
    end

    // -----------------------------------------------------------------------
    // Capture / consume / scan control and score
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pending_q    <= '0;
            hit_mask_q   <= '0;
            single_hit_q <= '0;
            busy_q       <= 1'b0;
            score_q      <= '0;
        end else begin
            single_hit_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (consume) begin
                        // Collisions seen on this same cycle go to the next frame.
                        single_hit_q <= pending_q;
                        hit_mask_q   <= pending_q;
                        pending_q    <= collision;
                        idx_q        <= '0;
                        state_q      <= S_SCAN;
                        busy_q       <= 1'b1;
                    end else begin
                        pending_q <= pending_q | collision;
                    end
                end
                S_SCAN: begin
                    pending_q <= pending_q | collision;
                    if (sel_hit) begin
                        score_q <= score_next;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Digit registers: a hit digit is redrawn while the scan visits it
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUMBERS; i++) begin
            if (reset) begin
                digits_q[i] <= reset_digit(i);
            end else if ((state_q == S_SCAN) && (idx_q == IDX_W'(i)) && hit_mask_q[i]) begin
                digits_q[i] <= new_digit;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NUMBERS; g++) begin : g_nts
        assign numbersToShow[g*4 +: 4] = digits_q[g];
    end

    assign singleHit = single_hit_q;
    assign score     = score_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_number_hit_scorer.sv
// Self-checking bench for number_hit_scorer. A behavioural model tracks the
// score as an integer and the digits as an int array, and advances the LFSR
// with polynomial arithmetic. A compare process checks every output on each
// falling edge. Directed phases add hand-derived literal expectations.
module tb_number_hit_scorer;

    localparam int         N    = 3;
    localparam int         SD   = 4;
    localparam logic [7:0] SEED = 8'hA5;

    logic            clk          = 1'b0;
    logic            reset        = 1'b1;
    logic            startOfFrame = 1'b0;
    logic [N-1:0]    numbersDR    = '0;
    logic            playerDR     = 1'b0;
    logic [N-1:0]    showNum      = '0;
    logic [N-1:0]    singleHit;
    logic [N*4-1:0]  numbersToShow;
    logic [SD*4-1:0] score;
    logic            busy;

    number_hit_scorer #(.NUMBERS(N), .SCORE_DIGITS(SD), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .numbersDR(numbersDR), .playerDR(playerDR), .showNum(showNum),
        .singleHit(singleHit), .numbersToShow(numbersToShow),
        .score(score), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       lfsr_m;
    bit [N-1:0] pend_m, hit_m, sh_m;
    int       scan_m = -1;          // -1 when no scan is running
    int       score_m;              // plain integer, saturated at 9999
    int       dig_m [N];
    bit       model_ok = 1'b0;

    function automatic int lfsr_step(input int l);
        return ((l << 1) & 255) | ($countones(l & 'hB8) & 1);
    endfunction

    function automatic int digit_of(input int l);
        int v;
        v = l & 15;
        if (v == 0) return 1;
        if (v > 9) return v - 6;
        return v;
    endfunction

    function automatic logic [SD*4-1:0] to_bcd(input int v);
        logic [SD*4-1:0] r;
        int p;
        r = '0;
        p = v;
        for (int i = 0; i < SD; i++) begin
            r[i*4 +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    function automatic logic [N*4-1:0] exp_nts();
        logic [N*4-1:0] r;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(dig_m[i]);
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit [N-1:0] coll;
        if (reset) begin
            lfsr_m = (SEED == 8'h00) ? 1 : int'(SEED);
            pend_m = '0;
            hit_m  = '0;
            sh_m   = '0;
            scan_m = -1;
            score_m = 0;
            for (int j = 0; j < N; j++) dig_m[j] = ((j + 1) % 10 == 0) ? 1 : (j + 1) % 10;
            model_ok = 1'b1;
        end else begin
            coll = playerDR ? (numbersDR & showNum) : '0;
            sh_m = '0;
            if (scan_m >= 0) begin
                if (hit_m[scan_m]) begin
                    score_m = (score_m + dig_m[scan_m] > 9999) ? 9999 : score_m + dig_m[scan_m];
                    dig_m[scan_m] = digit_of(lfsr_m);
                end
                scan_m = (scan_m == N - 1) ? -1 : scan_m + 1;
                pend_m = pend_m | coll;
            end else if (startOfFrame && pend_m != 0) begin
                sh_m   = pend_m;
                hit_m  = pend_m;
                pend_m = coll;
                scan_m = 0;
            end else begin
                pend_m = pend_m | coll;
            end
            lfsr_m = lfsr_step(lfsr_m);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("singleHit", singleHit, sh_m);
            check("busy", busy, scan_m >= 0);
            check("score", score, to_bcd(score_m));
            check("numbersToShow", numbersToShow, exp_nts());
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic sof, input logic [N-1:0] ndr, input logic pdr, input logic [N-1:0] show);
        startOfFrame = sof;
        numbersDR    = ndr;
        playerDR     = pdr;
        showNum      = show;
        @(posedge clk);
        #2;
    endtask

    // One collision cycle on mask, a frame start, then the scan cycles.
    task automatic frame(input logic [N-1:0] mask);
        cyc(1'b0, mask, 1'b1, '1);
        cyc(1'b1, '0, 1'b0, '1);
        repeat (N) cyc(1'b0, '0, 1'b0, '1);
    endtask

    initial begin
        int pre, a, b, guard;
        logic [3:0] d1;
        logic [N-1:0] rn, rs;

        // Reset state
        repeat (2) cyc(1'b0, '0, 1'b0, '0);
        check("rst_nts", numbersToShow, 32'h321);
        check("rst_score", score, 32'h0);
        check("rst_singleHit", singleHit, 32'h0);
        check("rst_busy", busy, 32'h0);
        reset = 1'b0;

        // Five collision cycles on number 1, then one frame start
        repeat (5) cyc(1'b0, 3'b010, 1'b1, 3'b111);
        cyc(1'b1, '0, 1'b0, 3'b111);
        check("hit1_pulse", singleHit, 32'h2);
        check("hit1_busy", busy, 32'h1);
        cyc(1'b0, '0, 1'b0, 3'b111);
        check("hit1_pulse_gone", singleHit, 32'h0);
        repeat (2) cyc(1'b0, '0, 1'b0, 3'b111);
        check("hit1_score", score, 32'h0002);
        check("hit1_busy_done", busy, 32'h0);
        check("hit1_other0", numbersToShow[3:0], 32'h1);
        check("hit1_other2", numbersToShow[11:8], 32'h3);
        d1 = numbersToShow[7:4];
        check("hit1_digit_range", (d1 >= 4'd1 && d1 <= 4'd9), 32'h1);

        // Invisible number 0 never scores
        for (int f = 0; f < 3; f++) begin
            repeat (3) cyc(1'b0, 3'b001, 1'b1, 3'b110);
            cyc(1'b1, '0, 1'b0, 3'b110);
            check("hidden_no_pulse", singleHit, 32'h0);
            repeat (N) cyc(1'b0, '0, 1'b0, 3'b110);
        end
        check("hidden_score", score, 32'h0002);

        // Build the score up near 100, then hit numbers 0 and 2 together
        guard = 0;
        while (score_m < 92 && guard < 100) begin
            frame(3'b001);
            guard++;
        end
        pre = score_m;
        a   = dig_m[0];
        b   = dig_m[2];
        cyc(1'b0, 3'b101, 1'b1, '1);
        cyc(1'b1, '0, 1'b0, '1);
        check("dual_pulse", singleHit, 32'h5);
        repeat (N) cyc(1'b0, '0, 1'b0, '1);
        check("dual_score", score, to_bcd(pre + a + b));

        // Drive the score into saturation
        guard = 0;
        while (score_m != 9999 && guard < 3000) begin
            frame(3'b111);
            guard++;
        end
        check("sat_score", score, 32'h9999);
        for (int f = 0; f < 2; f++) begin
            cyc(1'b0, 3'b111, 1'b1, '1);
            cyc(1'b1, '0, 1'b0, '1);
            check("sat_pulse", singleHit, 32'h7);
            repeat (N) cyc(1'b0, '0, 1'b0, '1);
            check("sat_hold", score, 32'h9999);
        end

        // Frame start plus collision during a scan: kept for the next frame
        cyc(1'b0, 3'b010, 1'b1, '1);
        cyc(1'b1, '0, 1'b0, '1);
        check("scan_sof_first", singleHit, 32'h2);
        cyc(1'b1, 3'b100, 1'b1, '1);
        check("scan_sof_ignored", singleHit, 32'h0);
        repeat (3) cyc(1'b0, '0, 1'b0, '1);
        check("scan_sof_idle", busy, 32'h0);
        cyc(1'b1, '0, 1'b0, '1);
        check("scan_sof_deferred", singleHit, 32'h4);
        repeat (N) cyc(1'b0, '0, 1'b0, '1);

        // Reset in the middle of a scan
        cyc(1'b0, 3'b001, 1'b1, '1);
        cyc(1'b1, '0, 1'b0, '1);
        cyc(1'b0, '0, 1'b0, '1);
        reset = 1'b1;
        cyc(1'b0, '0, 1'b0, '1);
        check("midrst_nts", numbersToShow, 32'h321);
        check("midrst_score", score, 32'h0);
        check("midrst_singleHit", singleHit, 32'h0);
        check("midrst_busy", busy, 32'h0);
        reset = 1'b0;

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 2000; i++) begin
            rn = N'($urandom);
            rs = N'($urandom);
            cyc(($urandom_range(0, 7) == 0), rn, 1'($urandom), rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
